// File: rtl/sic1_host_ctrl.sv
// ---------------------------------------------------------------------------
// sic1_host_ctrl
//   Host-side controller for a SIC-1 style core. It turns host commands into
//   the core's set-PC / set-data / run handshakes, supervises a run until the
//   program halts by itself or the host stops it, and captures the core's
//   output bytes into a 4-entry FIFO for the host to drain.
//
//   Optional feature: define SIC1_HOST_CTRL_WDT_EN to enable a run watchdog.
//   A run that lasts WDT_LIMIT cycles is then stopped and wdt_trip is set.
//   Without the macro there is no cycle counter, no run limit, and wdt_trip
//   is tied to 0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   host command handshake
//   cmd_op            0=SETPC 1=WRITE 2=RUN 3=STOP 4=CLEAR, 5-7 illegal
//   cmd_data          PC value or data byte for SETPC / WRITE
//   core_data         byte to the core ui_in
//   core_set_pc       core uio_in[2]
//   core_set_data     core uio_in[3]
//   core_run          core uio_in[0]
//   core_halted       core uio_out[1]
//   core_uo           core output byte
//   core_out_strobe   core output strobe (level; rising edge pushes core_uo)
//   out_valid/ready   output FIFO handshake, out_data is the head byte
//   busy              controller is not idle
//   done              one-cycle pulse when a running program halts itself
//   err               sticky error, cleared by CLEAR
//   wdt_trip          sticky watchdog flag, cleared by CLEAR
// ---------------------------------------------------------------------------
module sic1_host_ctrl #(
   parameter logic [15:0] WDT_LIMIT = 16'd4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic [7:0] core_data,
   output logic       core_set_pc,
   output logic       core_set_data,
   output logic       core_run,
   input  logic       core_halted,
   input  logic [7:0] core_uo,
   input  logic       core_out_strobe,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       wdt_trip
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETPC, S_WRITE, S_RUN_START, S_RUNNING, S_STOPPING
   } state_t;

   localparam logic [2:0] OP_SETPC = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_RUN   = 3'd2;
   localparam logic [2:0] OP_STOP  = 3'd3;
   localparam logic [2:0] OP_CLEAR = 3'd4;

   state_t     state, state_nxt;
   logic [1:0] rs_cnt, rs_cnt_nxt;   // cycles spent waiting for the core to start
   logic [7:0] core_data_q;
   logic       err_q, done_q;
   logic       accept, load_data, cmd_err, clear_flags, done_set, wdt_set, wdt_hit;

   // FIFO
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] fifo_cnt;
   logic       strobe_q, push_req, push, pop, full, fifo_ovf;

   assign cmd_ready     = (state == S_IDLE) || (state == S_RUNNING);
   assign accept        = cmd_valid && cmd_ready;
   assign busy          = (state != S_IDLE);
   // Handshake outputs decode the state register, so an asynchronous reset
   // drops them immediately without waiting for a clock edge.
   assign core_set_pc   = (state == S_SETPC);
   assign core_set_data = (state == S_WRITE);
   assign core_run      = (state == S_RUN_START) || (state == S_RUNNING);
   assign core_data     = core_data_q;
   assign done          = done_q;
   assign err           = err_q;

   // ---------------- watchdog ----------------
`ifdef SIC1_HOST_CTRL_WDT_EN
   logic [15:0] cyc_cnt;
   logic        wdt_q;

   // Counter is held at zero outside RUNNING, so it is zero on entry.
   assign wdt_hit  = (state == S_RUNNING) && ((cyc_cnt + 16'd1) == WDT_LIMIT);
   assign wdt_trip = wdt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt <= 16'd0;
         wdt_q   <= 1'b0;
      end else begin
         cyc_cnt <= (state == S_RUNNING) ? cyc_cnt + 16'd1 : 16'd0;
         if (wdt_set)          wdt_q <= 1'b1;
         else if (clear_flags) wdt_q <= 1'b0;
      end
   end
`else
   // The limit only matters with the watchdog built in; keep the parameter
   // on the interface so both builds instantiate identically.
   logic unused_wdt_limit;
   assign unused_wdt_limit = ^WDT_LIMIT;
   assign wdt_hit  = 1'b0;
   assign wdt_trip = 1'b0;
`endif

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rs_cnt      <= 2'd0;
         core_data_q <= 8'd0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state  <= state_nxt;
         rs_cnt <= rs_cnt_nxt;
         done_q <= done_set;
         if (load_data) core_data_q <= cmd_data;
         // A new error wins over a CLEAR in the same cycle so it is never lost.
         if (cmd_err || fifo_ovf) err_q <= 1'b1;
         else if (clear_flags)    err_q <= 1'b0;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_nxt   = state;
      rs_cnt_nxt  = rs_cnt;
      load_data   = 1'b0;
      cmd_err     = accept && (cmd_op > OP_CLEAR);
      clear_flags = accept && (cmd_op == OP_CLEAR);
      done_set    = 1'b0;
      wdt_set     = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_SETPC: begin state_nxt = S_SETPC; load_data = 1'b1; end
                  OP_WRITE: begin state_nxt = S_WRITE; load_data = 1'b1; end
                  OP_RUN:   begin state_nxt = S_RUN_START; rs_cnt_nxt = 2'd0; end
                  default:  ;  // STOP idles, CLEAR/illegal handled above
               endcase
            end
         end
         S_SETPC, S_WRITE: state_nxt = S_IDLE;
         S_RUN_START: begin
            if (!core_halted) begin
               state_nxt = S_RUNNING;
            end else if (rs_cnt == 2'd2) begin
               // Core never left halt after three cycles of core_run.
               state_nxt = S_IDLE;
               cmd_err   = 1'b1;
            end else begin
               rs_cnt_nxt = rs_cnt + 2'd1;
            end
         end
         S_RUNNING: begin
            if (accept && (cmd_op == OP_SETPC || cmd_op == OP_WRITE || cmd_op == OP_RUN))
               cmd_err = 1'b1;
            // Self-halt outranks both the watchdog and a host STOP.
            if (core_halted) begin
               state_nxt = S_IDLE;
               done_set  = 1'b1;
            end else if (wdt_hit) begin
               state_nxt = S_STOPPING;
               wdt_set   = 1'b1;
            end else if (accept && cmd_op == OP_STOP) begin
               state_nxt = S_STOPPING;
            end
         end
         S_STOPPING: if (core_halted) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // ---------------- output FIFO ----------------
   assign push_req  = core_out_strobe && !strobe_q;
   assign out_valid = (fifo_cnt != 3'd0);
   assign full      = (fifo_cnt == 3'd4);
   assign pop       = out_valid && out_ready;
   // When full, a same-cycle pop frees the slot the push needs.
   assign push      = push_req && (!full || pop);
   assign fifo_ovf  = push_req && full && !pop;
   assign out_data  = fifo_mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_q <= 1'b0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         strobe_q <= core_out_strobe;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: ;
         endcase
      end
   end

   // NOTE: storage is not reset; the empty count already hides stale entries,
   // and leaving reset off lets the array map onto plain registers/RAM.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= core_uo;
   end

endmodule

// File: tb/tb_sic1_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sic1_host_ctrl
//   Directed self-checking bench for sic1_host_ctrl. The core is not
//   modelled; core_halted, core_uo and core_out_strobe are driven directly.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_sic1_host_ctrl;

   localparam logic [2:0] OP_SETPC = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_RUN   = 3'd2;
   localparam logic [2:0] OP_STOP  = 3'd3;
   localparam logic [2:0] OP_CLEAR = 3'd4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_data = 8'd0;
   logic [7:0] core_data;
   logic       core_set_pc, core_set_data, core_run;
   logic       core_halted = 1'b1;
   logic [7:0] core_uo = 8'd0;
   logic       core_out_strobe = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       busy, done, err, wdt_trip;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sic1_host_ctrl #(.WDT_LIMIT(16'd8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .core_data(core_data), .core_set_pc(core_set_pc), .core_set_data(core_set_data),
      .core_run(core_run), .core_halted(core_halted), .core_uo(core_uo),
      .core_out_strobe(core_out_strobe),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .err(err), .wdt_trip(wdt_trip)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command for one cycle; it is accepted at that edge.
   task automatic send_cmd(input logic [2:0] op, input logic [7:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic strobe_byte(input logic [7:0] b);
      core_uo         = b;
      core_out_strobe = 1'b1;
      tick();
      core_out_strobe = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #3;
      n_checks++; if ({busy, core_run, core_set_pc, core_set_data, out_valid, err, done, wdt_trip} !== 8'b0)
         $display("FAIL reset_flags: got %b want 00000000",
                  {busy, core_run, core_set_pc, core_set_data, out_valid, err, done, wdt_trip}); else n_pass++;
      n_checks++; if (core_data !== 8'h00) $display("FAIL reset_core_data: got %h want 00", core_data); else n_pass++;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_held_busy: got %b want 0", busy); else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_setpc_write();
      send_cmd(OP_SETPC, 8'h10);
      n_checks++; if ({core_set_pc, core_set_data, busy, cmd_ready} !== 4'b1010)
         $display("FAIL setpc_state: got %b want 1010", {core_set_pc, core_set_data, busy, cmd_ready}); else n_pass++;
      n_checks++; if (core_data !== 8'h10) $display("FAIL setpc_data: got %h want 10", core_data); else n_pass++;
      tick();
      n_checks++; if ({core_set_pc, busy} !== 2'b00) $display("FAIL setpc_end: got %b want 00", {core_set_pc, busy}); else n_pass++;
      n_checks++; if (core_data !== 8'h10) $display("FAIL setpc_hold: got %h want 10", core_data); else n_pass++;
      send_cmd(OP_WRITE, 8'hAA);
      n_checks++; if ({core_set_pc, core_set_data, core_run, busy} !== 4'b0101)
         $display("FAIL write_state: got %b want 0101", {core_set_pc, core_set_data, core_run, busy}); else n_pass++;
      n_checks++; if (core_data !== 8'hAA) $display("FAIL write_data: got %h want aa", core_data); else n_pass++;
      tick();
      n_checks++; if ({core_set_data, busy} !== 2'b00) $display("FAIL write_end: got %b want 00", {core_set_data, busy}); else n_pass++;
      n_checks++; if (core_data !== 8'hAA) $display("FAIL write_hold: got %h want aa", core_data); else n_pass++;
   endtask

   task automatic test_idle_cmds();
      send_cmd(OP_STOP, 8'h00);
      n_checks++; if ({busy, err, core_run} !== 3'b000) $display("FAIL idle_stop: got %b want 000", {busy, err, core_run}); else n_pass++;
      send_cmd(3'd6, 8'h00);
      n_checks++; if ({busy, err} !== 2'b01) $display("FAIL idle_illegal: got %b want 01", {busy, err}); else n_pass++;
      send_cmd(OP_CLEAR, 8'h00);
      n_checks++; if ({busy, err} !== 2'b00) $display("FAIL idle_clear: got %b want 00", {busy, err}); else n_pass++;
   endtask

   task automatic test_run_halt();
      int done_cnt = 0;
      send_cmd(OP_RUN, 8'h00);
      n_checks++; if ({core_run, busy, cmd_ready} !== 3'b110) $display("FAIL run_start: got %b want 110", {core_run, busy, cmd_ready}); else n_pass++;
      core_halted = 1'b0;
      tick();
      n_checks++; if ({core_run, cmd_ready} !== 2'b11) $display("FAIL run_running: got %b want 11", {core_run, cmd_ready}); else n_pass++;
      send_cmd(OP_WRITE, 8'h55);
      n_checks++; if ({err, core_run, core_set_data} !== 3'b110) $display("FAIL run_bad_cmd: got %b want 110", {err, core_run, core_set_data}); else n_pass++;
      n_checks++; if (core_data !== 8'hAA) $display("FAIL run_bad_cmd_data: got %h want aa", core_data); else n_pass++;
      send_cmd(OP_CLEAR, 8'h00);
      n_checks++; if ({err, core_run} !== 2'b01) $display("FAIL run_clear: got %b want 01", {err, core_run}); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         if (done) done_cnt++;
         tick();
      end
      n_checks++; if (done_cnt !== 0) $display("FAIL run_early_done: got %0d want 0", done_cnt); else n_pass++;
      core_halted = 1'b1;
      tick();
      n_checks++; if ({done, core_run, busy, err} !== 4'b1000) $display("FAIL run_self_halt: got %b want 1000", {done, core_run, busy, err}); else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL run_done_width: got %b want 0", done); else n_pass++;
   endtask

   task automatic test_run_timeout();
      send_cmd(OP_RUN, 8'h00);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (core_run !== 1'b1) $display("FAIL timeout_run_c%0d: got %b want 1", i, core_run); else n_pass++;
         tick();
      end
      n_checks++; if ({core_run, busy, err} !== 3'b001) $display("FAIL timeout_end: got %b want 001", {core_run, busy, err}); else n_pass++;
      send_cmd(OP_CLEAR, 8'h00);
      n_checks++; if (err !== 1'b0) $display("FAIL timeout_clear: got %b want 0", err); else n_pass++;
   endtask

   task automatic test_stop();
      send_cmd(OP_RUN, 8'h00);
      core_halted = 1'b0;
      tick();
      tick();
      send_cmd(OP_STOP, 8'h00);
      n_checks++; if ({core_run, busy, cmd_ready} !== 3'b010) $display("FAIL stop_state: got %b want 010", {core_run, busy, cmd_ready}); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b1) $display("FAIL stop_wait: got %b want 1", busy); else n_pass++;
      core_halted = 1'b1;
      tick();
      n_checks++; if ({busy, done} !== 2'b00) $display("FAIL stop_end: got %b want 00", {busy, done}); else n_pass++;
      // STOP and self-halt in the same RUNNING cycle
      send_cmd(OP_RUN, 8'h00);
      core_halted = 1'b0;
      tick();
      core_halted = 1'b1;
      send_cmd(OP_STOP, 8'h00);
      n_checks++; if ({done, busy, core_run} !== 3'b100) $display("FAIL stop_priority: got %b want 100", {done, busy, core_run}); else n_pass++;
      tick();
   endtask

   task automatic test_watchdog();
      send_cmd(OP_RUN, 8'h00);
      core_halted = 1'b0;
      tick();
`ifdef SIC1_HOST_CTRL_WDT_EN
      repeat (7) tick();
      n_checks++; if (core_run !== 1'b1) $display("FAIL wdt_before: got %b want 1", core_run); else n_pass++;
      tick();
      n_checks++; if ({core_run, wdt_trip, busy} !== 3'b011) $display("FAIL wdt_trip: got %b want 011", {core_run, wdt_trip, busy}); else n_pass++;
      core_halted = 1'b1;
      tick();
      n_checks++; if ({busy, done} !== 2'b00) $display("FAIL wdt_idle: got %b want 00", {busy, done}); else n_pass++;
      send_cmd(OP_CLEAR, 8'h00);
      n_checks++; if (wdt_trip !== 1'b0) $display("FAIL wdt_clear: got %b want 0", wdt_trip); else n_pass++;
`else
      repeat (12) tick();
      n_checks++; if ({core_run, wdt_trip} !== 2'b10) $display("FAIL nowdt_long_run: got %b want 10", {core_run, wdt_trip}); else n_pass++;
      send_cmd(OP_STOP, 8'h00);
      core_halted = 1'b1;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL nowdt_stop: got %b want 0", busy); else n_pass++;
`endif
   endtask

   task automatic test_fifo();
      logic [7:0] exp_b [4] = '{8'd11, 8'd12, 8'd13, 8'd14};
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         strobe_byte(8'(i));
         if (i == 4) begin
            n_checks++; if ({err, out_valid} !== 2'b01) $display("FAIL fifo_fill: got %b want 01", {err, out_valid}); else n_pass++;
         end
      end
      n_checks++; if ({err, out_valid} !== 2'b11) $display("FAIL fifo_overflow: got %b want 11", {err, out_valid}); else n_pass++;
      n_checks++; if (out_data !== 8'd1) $display("FAIL fifo_head: got %0d want 1", out_data); else n_pass++;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         n_checks++; if (out_data !== 8'(i)) $display("FAIL fifo_pop%0d: got %0d want %0d", i, out_data, i); else n_pass++;
         tick();
      end
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL fifo_empty: got %b want 0", out_valid); else n_pass++;
      send_cmd(OP_CLEAR, 8'h00);
      for (int i = 10; i <= 13; i++) strobe_byte(8'(i));
      // push while full with a pop in the same cycle
      core_uo         = 8'd14;
      core_out_strobe = 1'b1;
      out_ready       = 1'b1;
      tick();
      core_out_strobe = 1'b0;
      out_ready       = 1'b0;
      n_checks++; if ({err, out_valid} !== 2'b01) $display("FAIL fifo_full_push_pop: got %b want 01", {err, out_valid}); else n_pass++;
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (out_data !== exp_b[i]) $display("FAIL fifo_wrap%0d: got %0d want %0d", i, out_data, exp_b[i]); else n_pass++;
         tick();
      end
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL fifo_wrap_empty: got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_async_reset();
      strobe_byte(8'h77);
      send_cmd(OP_RUN, 8'h00);
      core_halted = 1'b0;
      tick();
      n_checks++; if ({core_run, out_valid} !== 2'b11) $display("FAIL arst_pre: got %b want 11", {core_run, out_valid}); else n_pass++;
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if ({core_run, out_valid, busy} !== 3'b000) $display("FAIL arst_mid_cycle: got %b want 000", {core_run, out_valid, busy}); else n_pass++;
      #2;
      rst_n       = 1'b1;
      core_halted = 1'b1;
      tick();
      send_cmd(OP_SETPC, 8'h33);
      n_checks++; if ({core_set_pc, busy} !== 2'b11) $display("FAIL arst_after_setpc: got %b want 11", {core_set_pc, busy}); else n_pass++;
      n_checks++; if (core_data !== 8'h33) $display("FAIL arst_after_data: got %h want 33", core_data); else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_setpc_write();
      test_idle_cmds();
      test_run_halt();
      test_run_timeout();
      test_stop();
      test_watchdog();
      test_fifo();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
